// File: rtl/binding_result_serializer_pkg.sv
// ============================================================================
// binding_result_serializer_pkg : shared types and constants for the result
// serializer and its checksum accumulator.            Rev 1.0
// ============================================================================
`default_nettype none

package binding_result_serializer_pkg;

    localparam int          NUM_WORDS = 9;
    localparam int          WIDTH     = 8;
    localparam int          IDX_W     = 4;
    localparam logic [7:0]  HEADER    = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_SUM  = 2'd3
    } state_t;

endpackage : binding_result_serializer_pkg

`default_nettype wire

// File: rtl/binding_result_serializer_checksum_acc.sv
// ============================================================================
// binding_checksum_acc : modular byte accumulator with seed load, add enable
// and two's-complement checksum output.                 Rev 1.0
// ============================================================================
`default_nettype none

module binding_checksum_acc
    import binding_result_serializer_pkg::*;
#(
    parameter int ACC_WIDTH = WIDTH
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 seed_load,
    input  logic [ACC_WIDTH-1:0] seed,
    input  logic                 add_en,
    input  logic [ACC_WIDTH-1:0] add_data,
    output logic [ACC_WIDTH-1:0] chk
);

    logic [ACC_WIDTH-1:0] r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (seed_load) begin
            r_acc <= seed;
        end else if (add_en) begin
            r_acc <= r_acc + add_data;
        end
    end

    // Byte that brings the running sum of the whole frame back to zero.
    assign chk = -r_acc;

endmodule : binding_checksum_acc

`default_nettype wire

// File: rtl/binding_result_serializer.sv
// ============================================================================
// binding_result_serializer : captures nine result lanes and streams them as
// header, nine data bytes and checksum over a valid/ready byte interface.
//                                                        Rev 1.0
// ============================================================================
`default_nettype none

module binding_result_serializer
    import binding_result_serializer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_1,
    input  logic [WIDTH-1:0] io_in_2,
    input  logic [WIDTH-1:0] io_in_3,
    input  logic [WIDTH-1:0] io_in_4,
    input  logic [WIDTH-1:0] io_in_5,
    input  logic [WIDTH-1:0] io_in_6,
    input  logic [WIDTH-1:0] io_in_7,
    input  logic [WIDTH-1:0] io_in_8,
    input  logic [WIDTH-1:0] io_in_9,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_data,
    output logic             io_out_last,
    output logic [7:0]       io_frame_cnt
);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_snap [NUM_WORDS];
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_frame_cnt;

    logic [WIDTH-1:0]   w_lanes [NUM_WORDS];
    logic [WIDTH-1:0]   w_cur_word;
    logic [WIDTH-1:0]   w_chk;
    logic               w_in_fire;
    logic               w_acc_add;
    logic               w_last_word;

    assign w_lanes[0] = io_in_1;
    assign w_lanes[1] = io_in_2;
    assign w_lanes[2] = io_in_3;
    assign w_lanes[3] = io_in_4;
    assign w_lanes[4] = io_in_5;
    assign w_lanes[5] = io_in_6;
    assign w_lanes[6] = io_in_7;
    assign w_lanes[7] = io_in_8;
    assign w_lanes[8] = io_in_9;

    assign w_cur_word  = r_snap[r_idx];
    assign w_last_word = (r_idx == IDX_W'(NUM_WORDS - 1));

    // Outputs decode from registered state only; io_out_ready and io_in_valid
    // steer just the next-state and register enables.
    always_comb begin
        w_state_next = r_state;
        io_in_ready  = 1'b0;
        io_out_valid = 1'b0;
        io_out_data  = '0;
        io_out_last  = 1'b0;
        w_in_fire    = 1'b0;
        w_acc_add    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                io_in_ready = 1'b1;
                w_in_fire   = io_in_valid;
                if (io_in_valid) begin
                    w_state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                io_out_valid = 1'b1;
                io_out_data  = HEADER;
                if (io_out_ready) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                io_out_valid = 1'b1;
                io_out_data  = w_cur_word;
                w_acc_add    = io_out_ready;
                if (io_out_ready && w_last_word) begin
                    w_state_next = ST_SUM;
                end
            end
            ST_SUM: begin
                io_out_valid = 1'b1;
                io_out_data  = w_chk;
                io_out_last  = 1'b1;
                if (io_out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_in_fire) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_snap[i] <= w_lanes[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx <= '0;
        end else if (w_in_fire) begin
            r_idx <= '0;
        end else if (r_state == ST_HDR && io_out_ready) begin
            r_idx <= '0;
        end else if (r_state == ST_DATA && io_out_ready && !w_last_word) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt <= '0;
        end else if (r_state == ST_SUM && io_out_ready) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign io_frame_cnt = r_frame_cnt;

    binding_checksum_acc #(
        .ACC_WIDTH (WIDTH)
    ) u_checksum_acc (
        .clk       (clk),
        .reset     (reset),
        .seed_load (w_in_fire),
        .seed      (HEADER),
        .add_en    (w_acc_add),
        .add_data  (w_cur_word),
        .chk       (w_chk)
    );

endmodule : binding_result_serializer

`default_nettype wire
